sram_bank_arbiter: RTL

Shares the two 32x512 single-port SRAM macros (bank 0 and bank 1) between the Wishbone slave path and one internal master port (m1, core/DMA side). It decodes a 2 KiB-per-bank word space, grants each bank to at most one requester per cycle with per-bank round-robin on conflict, and drives the macros' active-low chip-select, write-enable, address, data and mask pins. It sits inside user_proj, between the Wishbone/internal logic and the macro pins.

---
 rtl/sram_bank_arbiter.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/sram_bank_arbiter.sv
// Shares two single-port SRAM banks between the Wishbone slave and the m1 port.
// Latency: pins driven combinationally on grant; WB write ack +1, WB read ack +2, m1 rvalid +1.
// Backpressure: a losing requester is held off (no m1_gnt / WB stays in IDLE) and retries next cycle.
module sram_bank_arbiter #(
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic [31:0] wbs_dat_o,
    output logic        wbs_ack_o,
    input  logic        m1_req,
    input  logic        m1_we,
    input  logic [9:0]  m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic [3:0]  m1_wmask,
    output logic        m1_gnt,
    output logic        m1_rvalid,
    output logic [31:0] m1_rdata,
    output logic        o_csb0,
    output logic        o_web0,
    output logic [8:0]  o_waddr0,
    output logic [31:0] o_din0,
    output logic [3:0]  o_wmask0,
    input  logic [31:0] i_dout0,
    output logic        o_csb0_1,
    output logic        o_web0_1,
    output logic [8:0]  o_waddr0_1,
    output logic [31:0] o_din0_1,
    output logic [3:0]  o_wmask0_1,
    input  logic [31:0] i_dout0_1
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_RDWAIT = 2'd1;
    localparam logic [1:0] ST_ACK    = 2'd2;

    logic [1:0]  state;
    logic        wb_bank_q;     // bank of the WB read in flight
    logic        rbank_q;       // bank of the m1 read in flight
    logic [1:0]  last_m1;       // per bank: 1 = m1 won the last grant there

    logic        wb_hit;
    logic        wb_req;
    logic        wb_bank;
    logic [8:0]  wb_word;
    logic [3:0]  wb_mask;
    logic        m1_req_ok;
    logic [1:0]  wb_req_bank;
    logic [1:0]  m1_req_bank;
    logic [1:0]  gnt_wb;
    logic [1:0]  gnt_m1;
    logic [3:0]  m1_mask;
    logic        wb_gnt;
    logic        unused_adr_lsb;

    // Byte-lane bits of the WB address carry no information for a word-wide macro.
    assign unused_adr_lsb = ^wbs_adr_i[1:0];

    assign wb_hit    = wbs_cyc_i && wbs_stb_i && (wbs_adr_i[31:12] == BASE_ADDR[31:12]);
    assign wb_req    = wb_hit && (state == ST_IDLE) && !wb_rst_i;
    assign wb_bank   = wbs_adr_i[11];
    assign wb_word   = wbs_adr_i[10:2];
    assign wb_mask   = wbs_we_i ? wbs_sel_i : 4'b0000;
    assign m1_req_ok = m1_req && !wb_rst_i;
    assign m1_mask   = m1_we ? m1_wmask : 4'b0000;

    // Per-bank request vectors and round-robin grant: on conflict the side that did not win last time goes.
    always_comb begin
        wb_req_bank = {wb_req && wb_bank, wb_req && !wb_bank};
        m1_req_bank = {m1_req_ok && m1_addr[9], m1_req_ok && !m1_addr[9]};
        gnt_wb      = wb_req_bank & (~m1_req_bank | last_m1);
        gnt_m1      = m1_req_bank & (~wb_req_bank | ~last_m1);
    end

    assign wb_gnt = |gnt_wb;
    assign m1_gnt = |gnt_m1;

    // Bank 0 pin mux: idle unless one requester owns the bank this cycle.
    always_comb begin
        o_csb0   = 1'b1;
        o_web0   = 1'b1;
        o_waddr0 = 9'd0;
        o_din0   = 32'd0;
        o_wmask0 = 4'b0000;
        if (gnt_wb[0]) begin
            o_csb0   = 1'b0;
            o_web0   = !wbs_we_i;
            o_waddr0 = wb_word;
            o_din0   = wbs_dat_i;
            o_wmask0 = wb_mask;
        end else if (gnt_m1[0]) begin
            o_csb0   = 1'b0;
            o_web0   = !m1_we;
            o_waddr0 = m1_addr[8:0];
            o_din0   = m1_wdata;
            o_wmask0 = m1_mask;
        end
    end

    // Bank 1 pin mux, same structure as bank 0.
    always_comb begin
        o_csb0_1   = 1'b1;
        o_web0_1   = 1'b1;
        o_waddr0_1 = 9'd0;
        o_din0_1   = 32'd0;
        o_wmask0_1 = 4'b0000;
        if (gnt_wb[1]) begin
            o_csb0_1   = 1'b0;
            o_web0_1   = !wbs_we_i;
            o_waddr0_1 = wb_word;
            o_din0_1   = wbs_dat_i;
            o_wmask0_1 = wb_mask;
        end else if (gnt_m1[1]) begin
            o_csb0_1   = 1'b0;
            o_web0_1   = !m1_we;
            o_waddr0_1 = m1_addr[8:0];
            o_din0_1   = m1_wdata;
            o_wmask0_1 = m1_mask;
        end
    end

    // Last-winner flags: any granted bank records whether m1 took it; reset favours WB first.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            last_m1 <= 2'b11;
        end else begin
            last_m1 <= (last_m1 & ~(gnt_wb | gnt_m1)) | gnt_m1;
        end
    end

    // Wishbone FSM: request in IDLE, wait one cycle for macro read data, then a single ack cycle.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state     <= ST_IDLE;
            wbs_ack_o <= 1'b0;
            wbs_dat_o <= 32'd0;
            wb_bank_q <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    wbs_ack_o <= 1'b0;
                    if (wb_gnt) begin
                        wb_bank_q <= wb_bank;
                        if (wbs_we_i) begin
                            state     <= ST_ACK;
                            wbs_ack_o <= 1'b1;
                        end else begin
                            state <= ST_RDWAIT;
                        end
                    end
                end
                ST_RDWAIT: begin
                    if (wbs_cyc_i) begin
                        wbs_dat_o <= wb_bank_q ? i_dout0_1 : i_dout0;
                        wbs_ack_o <= 1'b1;
                        state     <= ST_ACK;
                    end else begin
                        wbs_ack_o <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                default: begin
                    wbs_ack_o <= 1'b0;
                    state     <= ST_IDLE;
                end
            endcase
        end
    end

    // m1 read tracking: remember that a read was granted and on which bank, for one cycle.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            m1_rvalid <= 1'b0;
            rbank_q   <= 1'b0;
        end else begin
            m1_rvalid <= m1_gnt && !m1_we;
            if (m1_gnt) begin
                rbank_q <= m1_addr[9];
            end
        end
    end

    assign m1_rdata = m1_rvalid ? (rbank_q ? i_dout0_1 : i_dout0) : 32'd0;

endmodule
